// File: rtl/prime_pkg.sv
// Shared definitions for the prime sequencer: the control FSM state encoding
// and the default candidate width.
package prime_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    CHECK,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/prime_sequencer_if.sv
// Prime output stream: a prime value qualified by a valid/ready handshake.
interface prime_sequencer_if #(parameter int WIDTH = prime_pkg::DEFAULT_WIDTH);

  logic [WIDTH-1:0] prime_out;
  logic             prime_valid;
  logic             prime_ready;

  modport master (output prime_out, output prime_valid, input prime_ready);
  modport slave  (input prime_out, input prime_valid, output prime_ready);

endinterface

// File: rtl/prime_rem_unit.sv
// Restoring remainder unit: one dividend bit per cycle, done pulses WIDTH
// cycles after start with rem = n % d. A new start restarts it.
module prime_rem_unit
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rem,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    cnt;

  function automatic logic [WIDTH-1:0] rem_step(input logic [WIDTH-1:0] r,
                                                input logic             b,
                                                input logic [WIDTH-1:0] dv);
    logic [WIDTH:0] t;
    t = {r, b};
    if (t >= {1'b0, dv}) t = t - {1'b0, dv};
    return t[WIDTH-1:0];
  endfunction

  // The first bit is consumed on the start edge so the last one lands in
  // time for done to rise exactly WIDTH cycles after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      shift <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (start) begin
      rem   <= rem_step('0, n[WIDTH-1], d);
      shift <= n << 1;
      cnt   <= CW'(WIDTH - 1);
      done  <= 1'b0;
    end else if (cnt != '0) begin
      rem   <= rem_step(rem, shift[WIDTH-1], d);
      shift <= shift << 1;
      cnt   <= cnt - 1'b1;
      done  <= (cnt == CW'(1));
    end else begin
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/prime_sequencer.sv
// Enumerates all primes in [2, 2**WIDTH-1] by trial division and streams
// them on a valid/ready port.
module prime_sequencer
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  prime_sequencer_if.master         prime_if,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          count
);

  localparam logic [WIDTH-1:0] MAX_CAND = '1;
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  state_t           state, state_next;
  logic [WIDTH-1:0] cand, d, rem_q, div_rem, prime_reg;
  logic             div_start, div_done, transfer, d_sq_gt, last_cand;
  logic [2*WIDTH-1:0] d_sq;

  assign d_sq      = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
  assign d_sq_gt   = d_sq > {{WIDTH{1'b0}}, cand};
  assign last_cand = (cand == MAX_CAND);
  assign transfer  = (state == EMIT) && prime_if.prime_ready;

  prime_rem_unit #(.WIDTH(WIDTH)) u_rem (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .n     (cand),
    .d     (d),
    .rem   (div_rem),
    .done  (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_next = LOAD;
      LOAD: begin
        if (d_sq_gt) begin
          state_next = EMIT;
        end else begin
          div_start  = 1'b1;
          state_next = DIV;
        end
      end
      DIV:   if (div_done) state_next = CHECK;
      CHECK: begin
        if (rem_q == '0) state_next = last_cand ? DONE : LOAD;
        else             state_next = LOAD;
      end
      EMIT:  if (transfer) state_next = last_cand ? DONE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Candidate advance compares against the top value first so cand never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand      <= '0;
      d         <= '0;
      count     <= '0;
      rem_q     <= '0;
      prime_reg <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cand  <= TWO;
            d     <= TWO;
            count <= '0;
          end
        end
        LOAD: if (d_sq_gt) prime_reg <= cand;
        DIV:  if (div_done) rem_q <= div_rem;
        CHECK: begin
          if (rem_q == '0) begin
            if (!last_cand) begin
              cand <= cand + 1'b1;
              d    <= TWO;
            end
          end else begin
            d <= d + 1'b1;
          end
        end
        EMIT: begin
          if (transfer) begin
            count <= count + 1'b1;
            if (!last_cand) begin
              cand <= cand + 1'b1;
              d    <= TWO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign prime_if.prime_out   = prime_reg;
  assign prime_if.prime_valid = (state == EMIT);
  assign busy                 = (state == LOAD) || (state == DIV) ||
                                (state == CHECK) || (state == EMIT);
  assign done                 = (state == DONE);

endmodule

// File: tb/tb_prime_sequencer.sv
// Bench for prime_sequencer: a WIDTH=5 instance under directed control and a
// WIDTH=8 instance under random backpressure, both checked against a sieve model.
module tb_prime_sequencer;

  localparam int P_UNK  = 0;
  localparam int P_IDLE = 1;
  localparam int P_RUN  = 2;
  localparam int P_FIN  = 3;

  logic clk = 1'b0;
  logic rst5 = 1'b1, start5 = 1'b0, ready5 = 1'b1;
  logic rst8 = 1'b1, start8 = 1'b0, ready8 = 1'b1;
  logic busy5, done5, busy8, done8;
  logic [4:0] count5;
  logic [7:0] count8;

  int vectors = 0;
  int miscompares = 0;

  int prime_tab[2][$];
  int xfer_log[2][$];
  int phase[2];
  int idx[2];
  logic prev_valid[2];
  int prev_out[2];
  logic prev_xfer[2];

  int lit5[11] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};

  always #5 clk = ~clk;

  prime_sequencer_if #(.WIDTH(5)) if5 ();
  prime_sequencer_if #(.WIDTH(8)) if8 ();

  assign if5.prime_ready = ready5;
  assign if8.prime_ready = ready8;

  prime_sequencer #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst5), .start(start5), .prime_if(if5),
    .busy(busy5), .done(done5), .count(count5)
  );

  prime_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .prime_if(if8),
    .busy(busy8), .done(done8), .count(count8)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sieve of Eratosthenes over [2, maxv]
  task automatic buildPrimes(input int k, input int maxv);
    bit comp[256];
    for (int i = 0; i < 256; i++) comp[i] = 1'b0;
    for (int i = 2; i <= maxv; i++) begin
      if (!comp[i]) begin
        prime_tab[k].push_back(i);
        for (int j = i * i; j <= maxv; j += i) comp[j] = 1'b1;
      end
    end
  endtask

  // Model: an enumeration run is an index into the sieve list that advances on
  // each handshake; start/rst are applied as seen before the next rising edge.
  task automatic modelStep(input int k, input logic v, input logic [31:0] po,
                           input logic b, input logic dn, input logic [31:0] cnt,
                           input logic rdy, input logic rs, input logic st);
    int n;
    string tag;
    logic xfer;
    n   = prime_tab[k].size();
    tag = (k == 0) ? "w5" : "w8";
    if (phase[k] == P_RUN && dn === 1'b1) begin
      checkOutput({tag, "_done_total"}, idx[k], n);
      phase[k] = P_FIN;
    end
    case (phase[k])
      P_IDLE: begin
        checkOutput({tag, "_idle_valid"}, {31'd0, v}, 0);
        checkOutput({tag, "_idle_busy"}, {31'd0, b}, 0);
        checkOutput({tag, "_idle_done"}, {31'd0, dn}, 0);
        checkOutput({tag, "_idle_count"}, cnt, 0);
        checkOutput({tag, "_idle_prime"}, po, 0);
      end
      P_RUN: begin
        checkOutput({tag, "_run_count"}, cnt, idx[k]);
        checkOutput({tag, "_run_busy"}, {31'd0, b}, 1);
        if (v === 1'b1) begin
          checkOutput({tag, "_extra_prime"}, {31'd0, idx[k] < n}, 1);
          if (idx[k] < n) checkOutput({tag, "_prime"}, po, prime_tab[k][idx[k]]);
          if (prev_valid[k] && !prev_xfer[k]) checkOutput({tag, "_hold"}, po, prev_out[k]);
        end
      end
      P_FIN: begin
        checkOutput({tag, "_fin_done"}, {31'd0, dn}, 1);
        checkOutput({tag, "_fin_busy"}, {31'd0, b}, 0);
        checkOutput({tag, "_fin_valid"}, {31'd0, v}, 0);
        checkOutput({tag, "_fin_count"}, cnt, n);
      end
      default: ;
    endcase
    xfer = (phase[k] == P_RUN) && (v === 1'b1) && rdy && !rs;
    prev_valid[k] = (v === 1'b1);
    prev_out[k]   = po;
    prev_xfer[k]  = xfer;
    if (rs) begin
      phase[k] = P_IDLE;
      idx[k] = 0;
      prev_valid[k] = 1'b0;
    end else if (st && (phase[k] == P_IDLE || phase[k] == P_FIN)) begin
      phase[k] = P_RUN;
      idx[k] = 0;
    end else if (xfer) begin
      idx[k]++;
      xfer_log[k].push_back(po);
    end
  endtask

  always @(negedge clk) begin
    modelStep(0, if5.prime_valid, 32'(if5.prime_out), busy5, done5, 32'(count5), ready5, rst5, start5);
    modelStep(1, if8.prime_valid, 32'(if8.prime_out), busy8, done8, 32'(count8), ready8, rst8, start8);
  end

  // One-cycle pulse of rst and/or start on the selected instance.
  task automatic applyStimulus(input int k, input logic rs, input logic st);
    if (k == 0) begin rst5 = rs; start5 = st; end
    else        begin rst8 = rs; start8 = st; end
    @(posedge clk); #1;
    if (k == 0) begin rst5 = 1'b0; start5 = 1'b0; end
    else        begin rst8 = 1'b0; start8 = 1'b0; end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitIdx(input int k, input int target, input int budget, input string name);
    int n = 0;
    while (idx[k] < target && n < budget) begin @(posedge clk); #1; n++; end
    checkOutput(name, {31'd0, idx[k] >= target}, 1);
  endtask

  task automatic waitFin(input int k, input int budget, input string name);
    int n = 0;
    while (phase[k] != P_FIN && n < budget) begin
      @(posedge clk); #1; n++;
      if (k == 1) ready8 = ($urandom_range(0, 3) != 0);
    end
    checkOutput(name, {31'd0, phase[k] == P_FIN}, 1);
  endtask

  task automatic checkLog5(input string name, input int len);
    checkOutput({name, "_len"}, xfer_log[0].size(), len);
    for (int i = 0; i < len; i++)
      checkOutput(name, (i < xfer_log[0].size()) ? xfer_log[0][i] : 0, lit5[i]);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      phase[k] = P_UNK; idx[k] = 0;
      prev_valid[k] = 1'b0; prev_out[k] = 0; prev_xfer[k] = 1'b0;
    end
    buildPrimes(0, 31);
    buildPrimes(1, 255);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst5 = 1'b0;
    rst8 = 1'b0;
    fork
      begin
        // Backpressure on 7, ignored mid-run start, full run
        xfer_log[0].delete();
        applyStimulus(0, 1'b0, 1'b1);
        waitIdx(0, 3, 500, "w5_reach_5");
        ready5 = 1'b0;
        begin
          int n = 0;
          while (!(if5.prime_valid && if5.prime_out == 5'd7) && n < 500) begin
            @(posedge clk); #1; n++;
          end
          checkOutput("w5_valid_7", {31'd0, if5.prime_valid}, 1);
        end
        stepCycles(20);
        checkOutput("w5_held_7", 32'(if5.prime_out), 7);
        ready5 = 1'b1;
        waitIdx(0, 5, 500, "w5_reach_11");
        applyStimulus(0, 1'b0, 1'b1);
        waitFin(0, 3000, "w5_run1_done");
        checkLog5("w5_run1_seq", 11);
        checkOutput("w5_run1_count", 32'(count5), 11);
        checkOutput("w5_run1_busy", {31'd0, busy5}, 0);

        // Restart from DONE, then reset while dividing candidate 8
        xfer_log[0].delete();
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("w5_restart_count", 32'(count5), 0);
        checkOutput("w5_restart_done", {31'd0, done5}, 0);
        waitIdx(0, 4, 500, "w5_reach_8");
        stepCycles(2);
        applyStimulus(0, 1'b1, 1'b0);
        checkLog5("w5_run2_seq", 4);
        checkOutput("w5_rstdiv_busy", {31'd0, busy5}, 0);

        // Reset while holding the first prime under backpressure
        ready5 = 1'b0;
        applyStimulus(0, 1'b0, 1'b1);
        begin
          int n = 0;
          while (!if5.prime_valid && n < 100) begin @(posedge clk); #1; n++; end
          checkOutput("w5_first_prime", 32'(if5.prime_out), 2);
        end
        stepCycles(3);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("w5_rstemit_valid", {31'd0, if5.prime_valid}, 0);
        checkOutput("w5_rstemit_prime", 32'(if5.prime_out), 0);

        xfer_log[0].delete();
        ready5 = 1'b1;
        applyStimulus(0, 1'b0, 1'b1);
        waitFin(0, 3000, "w5_run3_done");
        checkLog5("w5_run3_seq", 11);
      end
      begin
        xfer_log[1].delete();
        applyStimulus(1, 1'b0, 1'b1);
        waitFin(1, 40000, "w8_done");
        ready8 = 1'b1;
        checkOutput("w8_len", xfer_log[1].size(), 54);
        checkOutput("w8_last", (xfer_log[1].size() > 0) ? xfer_log[1][xfer_log[1].size()-1] : 0, 251);
        checkOutput("w8_count", 32'(count8), 54);
        for (int i = 0; i < prime_tab[1].size(); i++)
          checkOutput("w8_seq", (i < xfer_log[1].size()) ? xfer_log[1][i] : 0, prime_tab[1][i]);
      end
    join
    stepCycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
